// File: rtl/traffic_light_controller_if.sv
// traffic_light_controller_if: groups the approach demand, pedestrian request
// and light/indication outputs of the traffic light controller.
// master = controller side, slave = demand sources / light drivers side.
interface traffic_light_controller_if #(
    parameter int NUM_WAYS = 4
);
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    logic [NUM_WAYS-1:0]   demand;
    logic                  ped_req;
    logic [2*NUM_WAYS-1:0] lights;
    logic [WAY_W-1:0]      active_way;
    logic                  walk;

    modport master (
        input  demand,
        input  ped_req,
        output lights,
        output active_way,
        output walk
    );

    modport slave (
        output demand,
        output ped_req,
        input  lights,
        input  active_way,
        input  walk
    );
endinterface

// File: rtl/traffic_light_controller.sv
// traffic_light_controller: round-robin multi-approach signal sequencer.
// Cycles demanded approaches through GREEN -> YELLOW -> ALLRED, extending
// green while nobody else waits. Light codes: Green=00, Yellow=01, Red=10.
// Optional pedestrian walk phase is built only when PED_WALK_EN is defined;
// otherwise ped_req is ignored and walk is held at 0.
module traffic_light_controller #(
    parameter int NUM_WAYS       = 4,
    parameter int GREEN_CYCLES   = 16,
    parameter int YELLOW_CYCLES  = 4,
    parameter int ALL_RED_CYCLES = 2,
    parameter int WALK_CYCLES    = 8,
    parameter int CNT_W          = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    traffic_light_controller_if.master   bus
);
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    localparam logic [1:0] LT_GREEN  = 2'b00;
    localparam logic [1:0] LT_YELLOW = 2'b01;
    localparam logic [1:0] LT_RED    = 2'b10;

    localparam logic [CNT_W-1:0] CNT_GREEN   = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_YELLOW  = CNT_W'(YELLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ALLRED  = CNT_W'(ALL_RED_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_ALLRED = 2'b00,
        ST_GREEN  = 2'b01,
        ST_YELLOW = 2'b10,
        ST_WALK   = 2'b11
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [WAY_W-1:0]      way_q, way_d;
    logic [2*NUM_WAYS-1:0] lights_q, lights_d;
    logic [WAY_W:0]        pick_s;
    logic [NUM_WAYS-1:0]   own_mask_s;
    logic                  own_demand_s;
    logic                  other_demand_s;
    logic                  ped_pending_s;

    // Round-robin search starting after 'last', wrapping, 'last' checked last.
    // Returns {found, index}.
    function automatic logic [WAY_W:0] rr_pick(input logic [NUM_WAYS-1:0] req,
                                               input logic [WAY_W-1:0]    last);
        logic                found;
        logic [WAY_W-1:0]    pick;
        logic [NUM_WAYS-1:0] sh;
        int                  idx;
        found = 1'b0;
        pick  = last;
        for (int k = 1; k <= NUM_WAYS; k++) begin
            idx = (int'(last) + k) % NUM_WAYS;
            sh  = req >> idx;
            if (!found && sh[0]) begin
                found = 1'b1;
                pick  = WAY_W'(idx);
            end else begin
                pick  = pick;
            end
        end
        return {found, pick};
    endfunction

    // Light pattern for a given state: only the active way may be non-red.
    function automatic logic [2*NUM_WAYS-1:0] build_lights(input state_e           st,
                                                           input logic [WAY_W-1:0] way);
        logic [2*NUM_WAYS-1:0] l;
        l = {NUM_WAYS{LT_RED}};
        for (int i = 0; i < NUM_WAYS; i++) begin
            if ((WAY_W'(i) == way) && (st == ST_GREEN)) begin
                l[2*i +: 2] = LT_GREEN;
            end else if ((WAY_W'(i) == way) && (st == ST_YELLOW)) begin
                l[2*i +: 2] = LT_YELLOW;
            end else begin
                l[2*i +: 2] = LT_RED;
            end
        end
        return l;
    endfunction

    assign pick_s         = rr_pick(bus.demand, way_q);
    assign own_mask_s     = {{(NUM_WAYS-1){1'b0}}, 1'b1} << way_q;
    assign own_demand_s   = ((bus.demand & own_mask_s) != {NUM_WAYS{1'b0}});
    assign other_demand_s = ((bus.demand & ~own_mask_s) != {NUM_WAYS{1'b0}});

`ifdef PED_WALK_EN
    localparam logic [CNT_W-1:0] CNT_WALK = CNT_W'(WALK_CYCLES - 1);

    logic ped_q, ped_d;
    logic walk_q, walk_d;

    assign ped_pending_s = ped_q;

    // Pending pedestrian request: a new request wins over the end-of-walk clear.
    always_comb begin
        ped_d = ped_q;
        if (bus.ped_req) begin
            ped_d = 1'b1;
        end else if ((state_q == ST_WALK) && (cnt_q == CNT_ZERO)) begin
            ped_d = 1'b0;
        end else begin
            ped_d = ped_q;
        end
    end

    // Walk indication follows the state being entered.
    always_comb begin
        walk_d = (state_d == ST_WALK);
    end

    // Pedestrian state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ped_q  <= 1'b0;
            walk_q <= 1'b0;
        end else begin
            ped_q  <= ped_d;
            walk_q <= walk_d;
        end
    end

    assign bus.walk = walk_q;
`else
    logic unused_ped_s;

    assign ped_pending_s = 1'b0;
    assign unused_ped_s  = bus.ped_req ^ (WALK_CYCLES != 0);
    assign bus.walk      = 1'b0;
`endif

    // Phase sequencing: counter counts down each phase, decisions taken at 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        way_d   = way_q;
        case (state_q)
            ST_ALLRED: begin
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (ped_pending_s) begin
`ifdef PED_WALK_EN
                    state_d = ST_WALK;
                    cnt_d   = CNT_WALK;
`else
                    cnt_d   = CNT_ZERO;
`endif
                end else if (pick_s[WAY_W]) begin
                    state_d = ST_GREEN;
                    cnt_d   = CNT_GREEN;
                    way_d   = pick_s[WAY_W-1:0];
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_GREEN: begin
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (other_demand_s || ped_pending_s || !own_demand_s) begin
                    state_d = ST_YELLOW;
                    cnt_d   = CNT_YELLOW;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_YELLOW: begin
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d = ST_ALLRED;
                    cnt_d   = CNT_ALLRED;
                end
            end
`ifdef PED_WALK_EN
            ST_WALK: begin
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d = ST_ALLRED;
                    cnt_d   = CNT_ALLRED;
                end
            end
`endif
            default: begin
                state_d = ST_ALLRED;
                cnt_d   = CNT_ALLRED;
            end
        endcase
    end

    // Lights are computed from the state being entered so they change with it.
    always_comb begin
        lights_d = build_lights(state_d, way_d);
    end

    // Main state and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_ALLRED;
            cnt_q    <= CNT_ALLRED;
            way_q    <= {WAY_W{1'b0}};
            lights_q <= {NUM_WAYS{LT_RED}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            way_q    <= way_d;
            lights_q <= lights_d;
        end
    end

    assign bus.lights     = lights_q;
    assign bus.active_way = way_q;
endmodule

// File: tb/tb_traffic_light_controller.sv
// tb_traffic_light_controller: directed scenarios with hand-computed per-cycle
// expected outputs pushed into a scoreboard queue; a monitor pops and compares
// one entry after every clock edge.
module tb_traffic_light_controller;
    localparam int NW = 4;
    localparam logic [7:0] ALL_RED = 8'b10101010;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    traffic_light_controller_if #(.NUM_WAYS(NW)) tif ();

    traffic_light_controller #(
        .NUM_WAYS(NW), .GREEN_CYCLES(16), .YELLOW_CYCLES(4),
        .ALL_RED_CYCLES(2), .WALK_CYCLES(8), .CNT_W(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (tif)
    );

    typedef struct packed {
        logic [7:0] lights;
        logic [1:0] way;
        logic       walk;
        logic [7:0] tag;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   test_id = 0;

    // 0 = all red, 1 = green on w, 2 = yellow on w
    function automatic logic [7:0] pat(input int st, input int w);
        logic [7:0] l;
        l = ALL_RED;
        if (st == 1) l[2*w +: 2] = 2'b00;
        else if (st == 2) l[2*w +: 2] = 2'b01;
        return l;
    endfunction

    task automatic expect_n(input int n, input logic [7:0] l, input int w, input logic wk);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.lights = l;
            e.way    = 2'(w);
            e.walk   = wk;
            e.tag    = 8'(test_id);
            sb_q.push_back(e);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        tif.demand  = 4'b0000;
        tif.ped_req = 1'b0;
        expect_n(2, ALL_RED, 0, 1'b0);
        reset = 1'b0;
    endtask

    // Monitor: compare one scoreboard entry after each edge.
    initial begin
        exp_t e;
        int   nonred;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if ({tif.lights, tif.active_way, tif.walk} !== {e.lights, e.way, e.walk}) begin
                    errors++;
                    $display("FAIL outputs test=%0d chk=%0d got lights=%b way=%0d walk=%b exp lights=%b way=%0d walk=%b",
                             e.tag, checks, tif.lights, tif.active_way, tif.walk, e.lights, e.way, e.walk);
                end
                nonred = 0;
                for (int i = 0; i < NW; i++) begin
                    if (tif.lights[2*i +: 2] !== 2'b10) nonred++;
                end
                checks++;
                if (nonred > 1) begin
                    errors++;
                    $display("FAIL exclusive test=%0d got nonred=%0d exp <=1", e.tag, nonred);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin
        reset       = 1'b1;
        tif.demand  = 4'b0000;
        tif.ped_req = 1'b0;

        // Reset / idle
        test_id = 1;
        do_reset();
        expect_n(100, ALL_RED, 0, 1'b0);

        // Single demand with extension, then competing demand
        test_id = 2;
        do_reset();
        tif.demand = 4'b0010;
        expect_n(1, ALL_RED, 0, 1'b0);
        expect_n(60, pat(1, 1), 1, 1'b0);
        tif.demand = 4'b1010;
        expect_n(4, pat(2, 1), 1, 1'b0);
        expect_n(2, ALL_RED, 1, 1'b0);
        expect_n(16, pat(1, 3), 3, 1'b0);

        // Round-robin with all demanding
        test_id = 3;
        do_reset();
        tif.demand = 4'b1111;
        expect_n(1, ALL_RED, 0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            int w;
            w = (k + 1) % 4;
            expect_n(16, pat(1, w), w, 1'b0);
            expect_n(4, pat(2, w), w, 1'b0);
            expect_n(2, ALL_RED, w, 1'b0);
        end
        expect_n(16, pat(1, 1), 1, 1'b0);

        // Minimum green despite demand dropping
        test_id = 4;
        do_reset();
        tif.demand = 4'b0100;
        expect_n(1, ALL_RED, 0, 1'b0);
        expect_n(3, pat(1, 2), 2, 1'b0);
        tif.demand = 4'b0000;
        expect_n(13, pat(1, 2), 2, 1'b0);
        expect_n(4, pat(2, 2), 2, 1'b0);
        expect_n(50, ALL_RED, 2, 1'b0);

        // Reset on the second yellow cycle
        test_id = 5;
        do_reset();
        tif.demand = 4'b1000;
        expect_n(1, ALL_RED, 0, 1'b0);
        expect_n(3, pat(1, 3), 3, 1'b0);
        tif.demand = 4'b0000;
        expect_n(13, pat(1, 3), 3, 1'b0);
        expect_n(2, pat(2, 3), 3, 1'b0);
        reset = 1'b1;
        expect_n(1, ALL_RED, 0, 1'b0);
        reset = 1'b0;
        tif.demand = 4'b1000;
        expect_n(1, ALL_RED, 0, 1'b0);
        expect_n(5, pat(1, 3), 3, 1'b0);

        // Pedestrian request during way 2 green
        test_id = 6;
        do_reset();
        tif.demand = 4'b0100;
        expect_n(1, ALL_RED, 0, 1'b0);
        expect_n(3, pat(1, 2), 2, 1'b0);
        tif.ped_req = 1'b1;
        expect_n(1, pat(1, 2), 2, 1'b0);
        tif.ped_req = 1'b0;
`ifdef PED_WALK_EN
        expect_n(12, pat(1, 2), 2, 1'b0);
        expect_n(4, pat(2, 2), 2, 1'b0);
        expect_n(2, ALL_RED, 2, 1'b0);
        expect_n(8, ALL_RED, 2, 1'b1);
        // request on the edge that ends the walk stays pending
        tif.ped_req = 1'b1;
        expect_n(1, ALL_RED, 2, 1'b0);
        tif.ped_req = 1'b0;
        expect_n(1, ALL_RED, 2, 1'b0);
        expect_n(8, ALL_RED, 2, 1'b1);
        expect_n(2, ALL_RED, 2, 1'b0);
        expect_n(5, pat(1, 2), 2, 1'b0);
`else
        expect_n(42, pat(1, 2), 2, 1'b0);
`endif

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain got pending=%0d exp 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
